fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the byte-addressed, combinational-read instruction memory. Owns the program counter, drives the memory address, and captures each 32-bit little-endian word with its PC into a small fetch FIFO feeding decode over a valid/ready handshake. Handles branch/jump redirects with flush, and detects misaligned or out-of-range fetches. Sits between the instruction memory and the decode stage.

---
 rtl/fetch_ctrl_pkg.sv | 29 ++
 rtl/fetch_ctrl_if.sv | 16 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_ctrl.sv | 108 ++++++++++
 tb/tb_fetch_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and helpers for the instruction-fetch sequencer
// Contents: fetch_state_t FSM encoding, data/address widths, fetch_entry_t
// FIFO payload, and pc_legal() fetch-address legality check.
package fetch_ctrl_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // The last byte of the word is computed one bit wider so that an address
    // near 2^32 cannot wrap back into range and look legal.
    function automatic logic pc_legal(input logic [ADDR_W-1:0] pc,
                                      input int unsigned       mem_bytes);
        logic [ADDR_W:0] last_byte;
        last_byte = {1'b0, pc} + 33'd3;
        return (pc[1:0] == 2'b00) && (last_byte < {1'b0, mem_bytes});
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch-to-decode valid/ready handshake bundle
// Signals: out_valid (head valid), out_ready (decode accepts head),
// out_pc (PC of head), out_instr (head instruction word).
// master: fetch side, slave: decode side.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (output out_valid, output out_pc, output out_instr, input out_ready);
    modport slave  (input out_valid, input out_pc, input out_instr, output out_ready);

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
// Ports: clk, rst (sync, active-high), push/wdata, pop, flush (empties the
// FIFO, wins over push/pop), rdata (head entry), count (occupancy).
// The caller never pushes when full without popping, nor pops when empty.
module fetch_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           wdata,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage is cleared on reset so the head reads as all-zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, redirect, fault, fetch FIFO
// Ports: clk, rst (sync, active-high); imem_addr/imem_data combinational
// instruction memory; redirect_valid/redirect_pc branch/jump target;
// dec (fetch_ctrl_if.master) decode handshake; fault/fault_pc sticky fault.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned       MEM_BYTES  = 128,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    fetch_ctrl_if.master       dec,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] fault_pc_n;
    logic              push, pop, flush, fetch_en;
    logic [CW-1:0]     count;
    fetch_entry_t      wentry, head;

    assign pop      = dec.out_valid && dec.out_ready;
    // A slot frees up at this edge if the head is accepted, so a full FIFO
    // still fetches every cycle while decode keeps up.
    assign fetch_en = (count < CW'(FIFO_DEPTH)) || pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            fault_pc <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            fault_pc <= fault_pc_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        fault_pc_n = fault_pc;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            BOOT: begin
                // Redirects are ignored while booting.
                state_n = RUN;
            end
            RUN, FAULT: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_n  = redirect_pc;
                    if (pc_legal(redirect_pc, MEM_BYTES)) begin
                        state_n = RUN;
                    end else begin
                        state_n    = FAULT;
                        fault_pc_n = redirect_pc;
                    end
                end else if ((state == RUN) && fetch_en) begin
                    if (pc_legal(pc, MEM_BYTES)) begin
                        push = 1'b1;
                        pc_n = pc + 32'd4;
                    end else begin
                        state_n    = FAULT;
                        fault_pc_n = pc;
                    end
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    assign wentry.pc    = pc;
    assign wentry.instr = imem_data;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .flush (flush),
        .rdata (head),
        .count (count)
    );

    assign imem_addr     = pc;
    assign fault         = (state == FAULT);
    assign dec.out_valid = (count != '0);
    assign dec.out_pc    = head.pc;
    assign dec.out_instr = head.instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard testbench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;

    logic [7:0]  mem_b [0:127];
    logic [63:0] exp_q [$];
    logic [63:0] exp_e;
    int          n_checks = 0;
    int          n_pass   = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .MEM_BYTES  (128),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (bus),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] pc);
        return (pc == 32'd0) ? 32'h0000_0013 : (32'h0010_0093 + (pc << 18) - 32'h0010_0000);
    endfunction

    // Byte-addressed memory, assembled little-endian.
    always_comb begin
        imem_data = 32'hDEAD_BEEF;
        if (imem_addr < 32'd125) begin
            imem_data = {mem_b[imem_addr[6:0] + 7'd3], mem_b[imem_addr[6:0] + 7'd2],
                         mem_b[imem_addr[6:0] + 7'd1], mem_b[imem_addr[6:0]]};
        end
    end

    task automatic test_reset(input logic rdy);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; bus.out_ready = rdy;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || imem_addr !== RESET_PC || fault !== 1'b0 || fault_pc !== 32'd0)
            $display("FAIL reset_ctrl valid=%b addr=%h fault=%b fault_pc=%h required 0/%h/0/0",
                     bus.out_valid, imem_addr, fault, fault_pc, RESET_PC);
        else n_pass++;
        n_checks++;
        if (bus.out_pc !== 32'd0 || bus.out_instr !== 32'd0)
            $display("FAIL reset_head pc=%h instr=%h required 0/0", bus.out_pc, bus.out_instr);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || imem_addr !== RESET_PC)
            $display("FAIL boot_cycle valid=%b addr=%h required 0/%h", bus.out_valid, imem_addr, RESET_PC);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC || bus.out_instr !== word(RESET_PC))
            $display("FAIL first_fetch valid=%b pc=%h instr=%h required 1/%h/%h",
                     bus.out_valid, bus.out_pc, bus.out_instr, RESET_PC, word(RESET_PC));
        else n_pass++;
    endtask

    // Runs right after test_reset(1): head 0 is being accepted already.
    task automatic test_stream();
        for (int k = 1; k < 8; k++) exp_q.push_back({32'(k * 4), word(32'(k * 4))});
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
                $display("FAIL stream_throughput cycle=%0d valid=%b required 1", c, bus.out_valid);
            end else begin
                exp_e = exp_q.pop_front();
                if ({bus.out_pc, bus.out_instr} !== exp_e)
                    $display("FAIL stream_data pc=%h instr=%h required %h/%h",
                             bus.out_pc, bus.out_instr, exp_e[63:32], exp_e[31:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        test_reset(1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd0 || bus.out_instr !== word(0))
                $display("FAIL stall_head valid=%b pc=%h required 1/0", bus.out_valid, bus.out_pc);
            else n_pass++;
        end
        n_checks++;
        if (dut.u_fifo.count !== 2'd2 || imem_addr !== 32'd8)
            $display("FAIL stall_full count=%0d addr=%h required 2/8", dut.u_fifo.count, imem_addr);
        else n_pass++;
        for (int k = 0; k < 6; k++) exp_q.push_back({32'(k * 4), word(32'(k * 4))});
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (bus.out_valid) begin
                exp_e = exp_q.pop_front();
                n_checks++;
                if ({bus.out_pc, bus.out_instr} !== exp_e)
                    $display("FAIL stall_drain pc=%h instr=%h required %h/%h",
                             bus.out_pc, bus.out_instr, exp_e[63:32], exp_e[31:0]);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL stall_timeout left=%0d required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_redirect();
        logic found;
        found = 1'b0;
        test_reset(1'b1);
        for (int k = 1; k < 5; k++) exp_q.push_back({32'(k * 4), word(32'(k * 4))});
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                exp_e = exp_q.pop_front();
                n_checks++;
                if ({bus.out_pc, bus.out_instr} !== exp_e)
                    $display("FAIL redirect_pre pc=%h required %h", bus.out_pc, exp_e[63:32]);
                else n_pass++;
                if (bus.out_pc == 32'h10) begin
                    found = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc = 32'h40;
                end
            end
        end
        n_checks++;
        if (!found) $display("FAIL redirect_wait head 0x10 seen=%b required 1", found);
        else n_pass++;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL redirect_bubble valid=%b required 0", bus.out_valid);
        else n_pass++;
        for (int k = 0; k < 3; k++) exp_q.push_back({32'h40 + 32'(k * 4), word(32'h40 + 32'(k * 4))});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1) begin
                $display("FAIL redirect_flow cycle=%0d valid=%b required 1", c, bus.out_valid);
            end else begin
                exp_e = exp_q.pop_front();
                if ({bus.out_pc, bus.out_instr} !== exp_e)
                    $display("FAIL redirect_data pc=%h required %h", bus.out_pc, exp_e[63:32]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_end_of_mem();
        test_reset(1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h70;
        @(negedge clk);
        redirect_valid = 1'b0; bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back({32'h70 + 32'(k * 4), word(32'h70 + 32'(k * 4))});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL eom_extra pc=%h required no output", bus.out_pc);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({bus.out_pc, bus.out_instr} !== exp_e)
                        $display("FAIL eom_data pc=%h required %h", bus.out_pc, exp_e[63:32]);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL eom_missing left=%0d required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h80 || bus.out_valid !== 1'b0 || imem_addr !== 32'h80)
            $display("FAIL eom_fault fault=%b fault_pc=%h valid=%b addr=%h required 1/80/0/80",
                     fault, fault_pc, bus.out_valid, imem_addr);
        else n_pass++;
    endtask

    task automatic test_fault_recovery();
        test_reset(1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        @(negedge clk);
        n_checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h22 || bus.out_valid !== 1'b0 || imem_addr !== 32'h22)
            $display("FAIL bad_redirect fault=%b fault_pc=%h valid=%b addr=%h required 1/22/0/22",
                     fault, fault_pc, bus.out_valid, imem_addr);
        else n_pass++;
        redirect_pc = 32'h20; bus.out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if (fault !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL recover_clear fault=%b valid=%b required 0/0", fault, bus.out_valid);
        else n_pass++;
        for (int k = 0; k < 3; k++) exp_q.push_back({32'h20 + 32'(k * 4), word(32'h20 + 32'(k * 4))});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1) begin
                $display("FAIL recover_flow cycle=%0d valid=%b required 1", c, bus.out_valid);
            end else begin
                exp_e = exp_q.pop_front();
                if ({bus.out_pc, bus.out_instr} !== exp_e)
                    $display("FAIL recover_data pc=%h required %h", bus.out_pc, exp_e[63:32]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        test_reset(1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut.u_fifo.count !== 2'd2) $display("FAIL mid_full count=%0d required 2", dut.u_fifo.count);
        else n_pass++;
        test_reset(1'b1);
        test_stream();
    endtask

    initial begin
        for (int a = 0; a < 128; a += 4) begin
            {mem_b[a + 3], mem_b[a + 2], mem_b[a + 1], mem_b[a]} = word(32'(a));
        end
        test_reset(1'b1);
        test_stream();
        test_stall();
        test_redirect();
        test_end_of_mem();
        test_fault_recovery();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
